register_gp: RTL and testbench

REGISTER_GP -- requirements
Module: register_gp

---
 rtl/register_gp.sv | 112 +++++++++++
 tb/tb_register_gp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/register_gp.sv
// General-purpose WIDTH-bit register: clear, load, increment and decrement,
// with a terminal-count pulse. Defining REGISTER_GP_SHIFT_EN adds serial shift-left and shift-right.
module register_gp #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_gp_n,
  input  logic             clr_gp,
  input  logic             load_gp,
  input  logic             inc_gp,
  input  logic             dec_gp,
  input  logic             write_gp,
  input  logic [WIDTH-1:0] data_gp,
`ifdef REGISTER_GP_SHIFT_EN
  input  logic             shl_gp,
  input  logic             shr_gp,
  input  logic             ser_in_gp,
`endif
  output logic [WIDTH-1:0] op_of_gp,
  output logic [WIDTH-1:0] bus_gp,
  output logic             carry_gp,
  output logic             zero_gp,
  output logic             tc_gp
);

`ifdef REGISTER_GP_SHIFT_EN
  typedef enum logic [2:0] {
    OP_HOLD, OP_CLR, OP_LOAD, OP_INC, OP_DEC, OP_SHL, OP_SHR
  } op_e;
`else
  typedef enum logic [2:0] {
    OP_HOLD, OP_CLR, OP_LOAD, OP_INC, OP_DEC
  } op_e;
`endif

  op_e              op_sel;
  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   inc_sum;
  logic             value_is_zero;

  assign value_is_zero = (value_q == '0);

  // One operation wins per edge, highest priority first.
  always_comb begin
    op_sel = OP_HOLD;
    if (clr_gp)       op_sel = OP_CLR;
    else if (load_gp) op_sel = OP_LOAD;
    else if (inc_gp)  op_sel = OP_INC;
    else if (dec_gp)  op_sel = OP_DEC;
`ifdef REGISTER_GP_SHIFT_EN
    else if (shl_gp)  op_sel = OP_SHL;
    else if (shr_gp)  op_sel = OP_SHR;
`endif
  end

  always_comb begin
    value_d = value_q;
    carry_d = carry_q;
    tc_d    = 1'b0;
    inc_sum = {1'b0, value_q} + (WIDTH + 1)'(1);
    case (op_sel)
      OP_CLR: begin
        value_d = RESET_VAL;
        carry_d = 1'b0;
      end
      OP_LOAD: value_d = data_gp;
      OP_INC: begin
        value_d = inc_sum[WIDTH-1:0];
        carry_d = inc_sum[WIDTH];
        tc_d    = inc_sum[WIDTH];
      end
      OP_DEC: begin
        value_d = value_q - WIDTH'(1);
        carry_d = value_is_zero;
        tc_d    = value_is_zero;
      end
`ifdef REGISTER_GP_SHIFT_EN
      OP_SHL: begin
        value_d = {value_q[WIDTH-2:0], ser_in_gp};
        carry_d = value_q[WIDTH-1];
      end
      OP_SHR: begin
        value_d = {ser_in_gp, value_q[WIDTH-1:1]};
        carry_d = value_q[0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_gp_n) begin
    if (!reset_gp_n) begin
      value_q <= RESET_VAL;
      carry_q <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
      tc_q    <= tc_d;
    end
  end

  assign op_of_gp = value_q;
  assign carry_gp = carry_q;
  assign tc_gp    = tc_q;
  assign zero_gp  = value_is_zero;
  assign bus_gp   = write_gp ? value_q : '0;

endmodule

// File: tb/tb_register_gp.sv
// Directed self-checking bench for register_gp (WIDTH=16, RESET_VAL=0).
// Shift steps are included when REGISTER_GP_SHIFT_EN is defined.
module tb_register_gp;

  logic        clk = 1'b0;
  logic        reset_gp_n;
  logic        clr_gp, load_gp, inc_gp, dec_gp, write_gp;
  logic [15:0] data_gp;
  logic [15:0] op_of_gp, bus_gp;
  logic        carry_gp, zero_gp, tc_gp;
`ifdef REGISTER_GP_SHIFT_EN
  logic        shl_gp, shr_gp, ser_in_gp;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  register_gp #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clk        (clk),
    .reset_gp_n (reset_gp_n),
    .clr_gp     (clr_gp),
    .load_gp    (load_gp),
    .inc_gp     (inc_gp),
    .dec_gp     (dec_gp),
    .write_gp   (write_gp),
    .data_gp    (data_gp),
`ifdef REGISTER_GP_SHIFT_EN
    .shl_gp     (shl_gp),
    .shr_gp     (shr_gp),
    .ser_in_gp  (ser_in_gp),
`endif
    .op_of_gp   (op_of_gp),
    .bus_gp     (bus_gp),
    .carry_gp   (carry_gp),
    .zero_gp    (zero_gp),
    .tc_gp      (tc_gp)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of controls, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic clr, input logic load, input logic inc,
                               input logic dec, input logic [15:0] data);
    clr_gp  = clr;
    load_gp = load;
    inc_gp  = inc;
    dec_gp  = dec;
    data_gp = data;
    @(posedge clk);
    #1;
    clr_gp  = 1'b0;
    load_gp = 1'b0;
    inc_gp  = 1'b0;
    dec_gp  = 1'b0;
  endtask

  initial begin
    reset_gp_n = 1'b0;
    clr_gp = 0; load_gp = 0; inc_gp = 0; dec_gp = 0; write_gp = 1'b1;
    data_gp = 16'h0000;
`ifdef REGISTER_GP_SHIFT_EN
    shl_gp = 0; shr_gp = 0; ser_in_gp = 0;
`endif
    #12;
    checkOutput("reset_op",    op_of_gp, 16'h0000);
    checkOutput("reset_carry", carry_gp, 1'b0);
    checkOutput("reset_tc",    tc_gp,    1'b0);
    checkOutput("reset_zero",  zero_gp,  1'b1);
    reset_gp_n = 1'b1;
    write_gp   = 1'b0;

    // Wrap from all-ones on increment
    applyStimulus(0, 1, 0, 0, 16'hFFFF);
    checkOutput("load_ffff_op",   op_of_gp, 16'hFFFF);
    checkOutput("load_ffff_zero", zero_gp,  1'b0);
    checkOutput("load_ffff_tc",   tc_gp,    1'b0);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkOutput("inc_wrap_op",    op_of_gp, 16'h0000);
    checkOutput("inc_wrap_carry", carry_gp, 1'b1);
    checkOutput("inc_wrap_zero",  zero_gp,  1'b1);
    checkOutput("inc_wrap_tc",    tc_gp,    1'b1);
    applyStimulus(0, 0, 0, 0, 16'h0000);
    checkOutput("hold_tc",    tc_gp,    1'b0);
    checkOutput("hold_carry", carry_gp, 1'b1);
    checkOutput("hold_op",    op_of_gp, 16'h0000);

    // Borrow on decrement from zero
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("clr_op",    op_of_gp, 16'h0000);
    checkOutput("clr_carry", carry_gp, 1'b0);
    applyStimulus(0, 0, 0, 1, 16'h0000);
    checkOutput("dec_wrap_op",    op_of_gp, 16'hFFFF);
    checkOutput("dec_wrap_carry", carry_gp, 1'b1);
    checkOutput("dec_wrap_tc",    tc_gp,    1'b1);
    applyStimulus(0, 0, 0, 1, 16'h0000);
    checkOutput("dec2_op",    op_of_gp, 16'hFFFE);
    checkOutput("dec2_carry", carry_gp, 1'b0);
    checkOutput("dec2_tc",    tc_gp,    1'b0);

    // Priority between simultaneous controls
    applyStimulus(1, 1, 1, 0, 16'h1234);
    checkOutput("prio_clr_op", op_of_gp, 16'h0000);
    applyStimulus(0, 1, 1, 0, 16'h1234);
    checkOutput("prio_load_op", op_of_gp, 16'h1234);
    applyStimulus(0, 0, 1, 1, 16'h0000);
    checkOutput("prio_inc_op",    op_of_gp, 16'h1235);
    checkOutput("prio_inc_carry", carry_gp, 1'b0);
    applyStimulus(0, 0, 0, 1, 16'h0000);
    checkOutput("dec_plain_op", op_of_gp, 16'h1234);
    applyStimulus(0, 1, 0, 0, 16'h00FF);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkOutput("inc_ripple_op",    op_of_gp, 16'h0100);
    checkOutput("inc_ripple_carry", carry_gp, 1'b0);
    checkOutput("inc_ripple_tc",    tc_gp,    1'b0);

    // Bus drive and asynchronous reset
    applyStimulus(0, 1, 0, 0, 16'h00A5);
    write_gp = 1'b1;
    #1;
    checkOutput("bus_on", bus_gp, 16'h00A5);
    write_gp = 1'b0;
    #1;
    checkOutput("bus_off", bus_gp, 16'h0000);
    write_gp = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0000);
    checkOutput("write_no_effect", op_of_gp, 16'h00A5);
    write_gp = 1'b0;
    #2;
    reset_gp_n = 1'b0;
    #1;
    checkOutput("async_rst_op",   op_of_gp, 16'h0000);
    checkOutput("async_rst_zero", zero_gp,  1'b1);
    inc_gp = 1'b1;
    #3;
    reset_gp_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkOutput("first_op_after_rst", op_of_gp, 16'h0001);
    applyStimulus(0, 1, 0, 0, 16'hFFFF);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkOutput("pre_rst_tc", tc_gp, 1'b1);
    #2;
    reset_gp_n = 1'b0;
    #1;
    checkOutput("async_rst_tc",    tc_gp,    1'b0);
    checkOutput("async_rst_carry", carry_gp, 1'b0);
    #3;
    reset_gp_n = 1'b1;

`ifdef REGISTER_GP_SHIFT_EN
    // Serial shifts and their priority below decrement
    applyStimulus(0, 1, 0, 0, 16'h8001);
    shl_gp = 1'b1; ser_in_gp = 1'b0;
    applyStimulus(0, 0, 0, 0, 16'h0000);
    shl_gp = 1'b0;
    checkOutput("shl_op",    op_of_gp, 16'h0002);
    checkOutput("shl_carry", carry_gp, 1'b1);
    checkOutput("shl_tc",    tc_gp,    1'b0);
    shr_gp = 1'b1; ser_in_gp = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0000);
    checkOutput("shr_op",    op_of_gp, 16'h8001);
    checkOutput("shr_carry", carry_gp, 1'b0);
    shl_gp = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0000);
    checkOutput("shl_over_shr_op", op_of_gp, 16'h0003);
    applyStimulus(0, 0, 0, 1, 16'h0000);
    shl_gp = 1'b0; shr_gp = 1'b0;
    checkOutput("dec_over_shift_op", op_of_gp, 16'h0002);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
